// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register: data-memory access over a req/ready handshake,
// write-back data selection, upstream stall generation, and sticky timeout/misalignment error.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  EX_MEM_RegWriteAddr,
  input  logic [31:0] EX_MEM_ALUOut,
  input  logic [31:0] EX_MEM_PC_4,
  input  logic [31:0] EX_MEM_MUXB_Data,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_MemRead,
  input  logic [1:0]  EX_MEM_MemtoReg,
  input  logic        EX_MEM_RegWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [4:0]  MEM_WB_RegWriteAddr,
  output logic [31:0] MEM_WB_WriteData,
  output logic        MEM_WB_RegWrite,
  output logic        mem_err
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic          mem_op, misaligned, timeout_hit;
  logic [31:0]   wb_data;

  assign mem_op      = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign misaligned  = mem_op && (EX_MEM_ALUOut[1:0] != 2'b00);
  assign timeout_hit = (state == WAIT) && (count == LAST) && !dmem_ready;

  // Gating with rst makes the request vanish the moment reset asserts, without waiting for a clock.
  assign dmem_req   = rst && mem_op && !misaligned && !timeout_hit;
  assign dmem_we    = EX_MEM_MemWrite;
  assign dmem_addr  = EX_MEM_ALUOut;
  assign dmem_wdata = EX_MEM_MUXB_Data;
  assign mem_stall  = dmem_req && !dmem_ready;

  always_comb begin
    unique case (EX_MEM_MemtoReg)
      2'b01:   wb_data = dmem_rdata;
      2'b10:   wb_data = EX_MEM_PC_4;
      default: wb_data = EX_MEM_ALUOut;
    endcase
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    state_nx = state;
    count_nx = count;
    unique case (state)
      IDLE: begin
        if (mem_stall) begin
          state_nx = WAIT;
          count_nx = CW'(1);
        end
      end
      WAIT: begin
        if (mem_stall) begin
          count_nx = count + CW'(1);
        end else begin
          state_nx = IDLE;
          count_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      count               <= '0;
      MEM_WB_RegWriteAddr <= '0;
      MEM_WB_WriteData    <= '0;
      MEM_WB_RegWrite     <= 1'b0;
      mem_err             <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (misaligned || timeout_hit) begin
        MEM_WB_RegWrite <= 1'b0;
        mem_err         <= 1'b1;
      end else if (mem_stall) begin
        MEM_WB_RegWrite <= 1'b0;
      end else begin
        MEM_WB_RegWriteAddr <= EX_MEM_RegWriteAddr;
        MEM_WB_WriteData    <= wb_data;
        MEM_WB_RegWrite     <= EX_MEM_RegWrite;
      end
    end
  end

endmodule
